// File: rtl/step_pacer_pkg.sv
// step_pacer_pkg: shared FSM state encoding, divisor width and level-to-divisor helper.
package step_pacer_pkg;
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;

    // Saturating subtract: a level larger than base never wraps below min.
    function automatic logic [DIV_W-1:0] calc_div(input logic [DIV_W-1:0] lvl,
                                                  input logic [DIV_W-1:0] base,
                                                  input logic [DIV_W-1:0] min);
        return (base > lvl && (base - lvl) > min) ? base - lvl : min;
    endfunction
endpackage

// File: rtl/step_pacer_if.sv
// step_pacer_if: control, step handshake and status bundle; turbo exists only with STEP_PACER_TURBO_EN.
interface step_pacer_if #(
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 16
);
    logic               slow_in;
    logic               start;
    logic               pause;
`ifdef STEP_PACER_TURBO_EN
    logic               turbo;
`endif
    logic               step_valid;
    logic               step_ready;
    logic [LEVEL_W-1:0] level;
    logic [CNT_W-1:0]   step_count;
    logic               running;
    logic               overrun;

    modport master (
`ifdef STEP_PACER_TURBO_EN
        input  turbo,
`endif
        input  slow_in, start, pause, step_ready,
        output step_valid, level, step_count, running, overrun
    );

    modport slave (
`ifdef STEP_PACER_TURBO_EN
        output turbo,
`endif
        output slow_in, start, pause, step_ready,
        input  step_valid, level, step_count, running, overrun
    );
endinterface

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: registers a synchronous input and flags its 0->1 transitions combinationally.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else        q <= din;

    assign rise = din & ~q;
endmodule

// File: rtl/step_pacer.sv
// step_pacer: divides slow_in rising edges by a level-dependent divisor into valid/ready step requests.
// Optional STEP_PACER_TURBO_EN adds a turbo input forcing the divisor to MIN_DIV.
module step_pacer
    import step_pacer_pkg::*;
#(
    parameter int BASE_DIV        = 8,
    parameter int MIN_DIV         = 1,
    parameter int STEPS_PER_LEVEL = 16,
    parameter int MAX_LEVEL       = 7,
    parameter int LEVEL_W         = 3,
    parameter int CNT_W           = 16
) (
    input logic          CLOCK_50,
    input logic          resetn,
    step_pacer_if.master bus
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_PAUSED = PAUSED;

    logic [1:0]         state;
    logic [DIV_W-1:0]   ecnt, div, base_div;
    logic [LEVEL_W-1:0] level;
    logic [CNT_W-1:0]   step_count;
    logic               step_valid, overrun, rise, slow_q;
    logic               counting, expire, xfer, lvl_up, clear;

    edge_detect_rise u_edge (
        .clk  (CLOCK_50),
        .rst_n(resetn),
        .din  (bus.slow_in),
        .q    (slow_q),
        .rise (rise)
    );

    always_comb begin
        base_div = calc_div(DIV_W'(level), DIV_W'(BASE_DIV), DIV_W'(MIN_DIV));
`ifdef STEP_PACER_TURBO_EN
        div      = bus.turbo ? DIV_W'(MIN_DIV) : base_div;
`else
        div      = base_div;
`endif
        counting = (state == S_RUN) && rise;
        expire   = counting && (ecnt == div - DIV_W'(1));
        xfer     = step_valid && bus.step_ready;
        lvl_up   = xfer && ((32'(step_count) + 32'd1) % STEPS_PER_LEVEL == 0);
        clear    = bus.start && (state != S_RUN);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ecnt       <= '0;
            level      <= '0;
            step_count <= '0;
            step_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= clear ? S_RUN :
                          (state == S_RUN && bus.pause) ? S_PAUSED :
                          (state == S_PAUSED && !bus.pause) ? S_RUN : state;
            step_valid <= expire || (step_valid && !xfer);
            if (clear) begin
                ecnt       <= '0;
                level      <= '0;
                step_count <= '0;
                overrun    <= 1'b0;
            end else begin
                // A counter left above a freshly shrunk divisor rolls over without a step.
                if (counting)
                    ecnt <= (ecnt >= div - DIV_W'(1)) ? '0 : ecnt + DIV_W'(1);
                if (expire && step_valid && !xfer)
                    overrun <= 1'b1;
                if (xfer && step_count != '1)
                    step_count <= step_count + CNT_W'(1);
                if (lvl_up && level != LEVEL_W'(MAX_LEVEL))
                    level <= level + LEVEL_W'(1);
            end
        end
    end

    assign bus.step_valid = step_valid;
    assign bus.level      = level;
    assign bus.step_count = step_count;
    assign bus.running    = (state == S_RUN);
    assign bus.overrun    = overrun;
endmodule
